timer_sched: RTL and testbench

Round-robin scheduler that shares a single down-counting timer among N requesting channels. Each channel requests a timeout of a given cycle count. The block arbitrates, loads the shared counter, and runs it to expiry. It then returns a one-cycle done pulse to the owning channel. It sits between client logic and the timer datapath, so one counter serves several timeout users in turn.

---
 rtl/timer_sched_if.sv | 26 ++
 rtl/timer_sched.sv | 109 ++++++++++
 tb/tb_timer_sched.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_sched_if.sv
// Bundle between client channels and the shared-timer scheduler.
// Handshake: req[i] is a level held high until gnt[i] pulses; req_val[i] is sampled on that grant edge.
interface timer_sched_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int ID_W = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_val;
  logic [N-1:0]   cancel;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [ID_W-1:0] active_id;
  logic [W-1:0]   remaining;

  modport master (
    output req, req_val, cancel,
    input  gnt, done, busy, active_id, remaining
  );

  modport slave (
    input  req, req_val, cancel,
    output gnt, done, busy, active_id, remaining
  );
endinterface

// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one down-counting timer among N channels.
// IDLE arbitrates from ptr, COUNT runs the timer, DONE emits the done pulse.
module timer_sched #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  timer_sched_if.slave  bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_cnt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_active;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    r_done;
  logic            r_busy;

  logic            w_any;
  logic [ID_W-1:0] w_sel;
  logic [ID_W:0]   w_idx;
  logic [W-1:0]    w_sel_val;
  logic [ID_W-1:0] w_next_ptr;
  logic            w_cancel;

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N)) w_idx = w_idx - (ID_W+1)'(N);
      if (bus.req[w_idx[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_sel_val  = bus.req_val[w_sel*W +: W];
  assign w_next_ptr = (r_active == ID_W'(N - 1)) ? '0 : r_active + ID_W'(1);
  assign w_cancel   = bus.cancel[r_active];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_active <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= COUNT;
            r_cnt    <= w_sel_val;
            r_active <= w_sel;
            r_gnt    <= N'(1) << w_sel;
            r_busy   <= 1'b1;
          end
        end
        COUNT: begin
          // Cancel takes priority over expiry; the count is frozen as-is.
          if (w_cancel) begin
            r_state <= IDLE;
            r_ptr   <= w_next_ptr;
            r_busy  <= 1'b0;
          end else if (r_cnt <= W'(1)) begin
            r_state <= DONE;
            r_done  <= N'(1) << r_active;
          end else begin
            r_cnt <= r_cnt - W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ptr   <= w_next_ptr;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.active_id = r_active;
  assign bus.remaining = r_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: per-scenario tasks, expected done events queued at grant time.
module tb_timer_sched;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int ID_W = 2;
  localparam int EW   = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic [N-1:0]  g, d, oh;
  int            at, dat, t0;

  timer_sched_if #(.N(N), .W(W)) bus();

  timer_sched #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst         = 1'b0;
    bus.req     = '0;
    bus.cancel  = '0;
    bus.req_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_val(input int ch, input int v);
    bus.req_val[ch*W +: W] = W'(v);
  endtask

  task automatic wait_gnt(output logic [N-1:0] og, output int oat);
    og  = '0;
    oat = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.gnt !== '0) begin
        og  = bus.gnt;
        oat = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic [N-1:0] od, output int oat);
    od  = '0;
    oat = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.done !== '0) begin
        od  = bus.done;
        oat = cyc;
        break;
      end
    end
  endtask

  task automatic push_done(input int ch, input int when);
    exp_q.push_back({8'(ch), 32'(when)});
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    bus.req = '1;
    bus.cancel = '0;
    bus.req_val = '1;
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== '0) begin failures++; $display("FAIL reset_gnt: got %b expected 0", bus.gnt); end
    checks++; if (bus.done !== '0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.active_id !== '0) begin failures++; $display("FAIL reset_active: got %0d expected 0", bus.active_id); end
    checks++; if (bus.remaining !== '0) begin failures++; $display("FAIL reset_remaining: got %0d expected 0", bus.remaining); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    bus.req = '0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    bus.req[2] = 1'b1;
    set_val(2, 5);
    t0 = cyc;
    wait_gnt(g, at);
    bus.req[2] = 1'b0;
    checks++; if (g !== 4'b0100) begin failures++; $display("FAIL single_gnt: got %b expected 0100", g); end
    checks++; if (at !== t0 + 1) begin failures++; $display("FAIL single_latency: got %0d expected %0d", at, t0 + 1); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy_rise: got %b expected 1", bus.busy); end
    checks++; if (bus.active_id !== 2'd2) begin failures++; $display("FAIL single_active: got %0d expected 2", bus.active_id); end
    push_done(2, at + 5);
    checks++; if (bus.remaining !== 8'd5) begin failures++; $display("FAIL single_rem0: got %0d expected 5", bus.remaining); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (bus.remaining !== W'(5 - k) || bus.done !== '0) begin
        failures++; $display("FAIL single_rem: got rem=%0d done=%b expected rem=%0d done=0", bus.remaining, bus.done, 5 - k);
      end
    end
    wait_done(d, dat);
    e  = exp_q.pop_front();
    oh = N'(1) << e[39:32];
    checks++; if (d !== oh || dat !== int'(e[31:0])) begin
      failures++; $display("FAIL single_done: got %b@%0d expected %b@%0d", d, dat, oh, e[31:0]);
    end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy_done: got %b expected 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== '0) begin
      failures++; $display("FAIL single_busy_fall: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_round_robin();
    int prev;
    do_reset();
    @(negedge clk);
    for (int c = 0; c < N; c++) set_val(c, 2);
    bus.req = '1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, at);
      if (i == 4) bus.req = '0;
      oh = N'(1) << (i % N);
      checks++; if (g !== oh) begin failures++; $display("FAIL rr_order[%0d]: got %b expected %b", i, g, oh); end
      if (i > 0) begin
        checks++; if (at - prev !== 4) begin failures++; $display("FAIL rr_spacing[%0d]: got %0d expected 4", i, at - prev); end
      end
      prev = at;
      push_done(i % N, at + 2);
      wait_done(d, dat);
      e  = exp_q.pop_front();
      oh = N'(1) << e[39:32];
      checks++; if (d !== oh || dat !== int'(e[31:0])) begin
        failures++; $display("FAIL rr_done[%0d]: got %b@%0d expected %b@%0d", i, d, dat, oh, e[31:0]);
      end
    end
  endtask

  task automatic test_zero_max();
    do_reset();
    @(negedge clk);
    bus.req[1] = 1'b1;
    set_val(1, 0);
    wait_gnt(g, at);
    bus.req[1] = 1'b0;
    push_done(1, at + 1);
    wait_done(d, dat);
    e  = exp_q.pop_front();
    oh = N'(1) << e[39:32];
    checks++; if (d !== oh || dat !== int'(e[31:0])) begin
      failures++; $display("FAIL zero_done: got %b@%0d expected %b@%0d", d, dat, oh, e[31:0]);
    end
    @(negedge clk);
    bus.req[1] = 1'b1;
    set_val(1, 255);
    wait_gnt(g, at);
    bus.req[1] = 1'b0;
    checks++; if (g !== 4'b0010 || bus.remaining !== 8'd255) begin
      failures++; $display("FAIL max_gnt: got %b rem=%0d expected 0010 rem=255", g, bus.remaining);
    end
    push_done(1, at + 255);
    for (int k = 1; k <= 254; k++) begin
      @(negedge clk);
      checks++; if (bus.remaining !== W'(255 - k) || bus.done !== '0) begin
        failures++; $display("FAIL max_rem: got rem=%0d done=%b expected rem=%0d done=0", bus.remaining, bus.done, 255 - k);
      end
    end
    wait_done(d, dat);
    e  = exp_q.pop_front();
    oh = N'(1) << e[39:32];
    checks++; if (d !== oh || dat !== int'(e[31:0])) begin
      failures++; $display("FAIL max_done: got %b@%0d expected %b@%0d", d, dat, oh, e[31:0]);
    end
    checks++; if (bus.remaining !== 8'd1) begin failures++; $display("FAIL max_nowrap: got %0d expected 1", bus.remaining); end
  endtask

  task automatic test_cancel();
    do_reset();
    @(negedge clk);
    bus.req[1] = 1'b1;
    set_val(1, 10);
    wait_gnt(g, at);
    t0 = at;
    checks++; if (g !== 4'b0010) begin failures++; $display("FAIL cancel_gnt1: got %b expected 0010", g); end
    bus.req[1]    = 1'b0;
    bus.req[2]    = 1'b1;
    set_val(2, 3);
    bus.cancel[3] = 1'b1;
    @(negedge clk);
    bus.cancel[3] = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.remaining !== 8'd9) begin
      failures++; $display("FAIL cancel_other: got busy=%b rem=%0d expected 1/9", bus.busy, bus.remaining);
    end
    @(negedge clk);
    bus.cancel[1] = 1'b1;
    @(negedge clk);
    bus.cancel[1] = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== '0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL cancel_idle: got busy=%b done=%b state=%0d expected 0/0/0", bus.busy, bus.done, dbg_state);
    end
    checks++; if (bus.remaining !== 8'd8) begin failures++; $display("FAIL cancel_frozen: got %0d expected 8", bus.remaining); end
    wait_gnt(g, at);
    bus.req[2] = 1'b0;
    checks++; if (g !== 4'b0100 || at !== t0 + 4) begin
      failures++; $display("FAIL cancel_next_gnt: got %b@%0d expected 0100@%0d", g, at, t0 + 4);
    end
    push_done(2, at + 3);
    wait_done(d, dat);
    e  = exp_q.pop_front();
    oh = N'(1) << e[39:32];
    checks++; if (d !== oh || dat !== int'(e[31:0])) begin
      failures++; $display("FAIL cancel_ch2_done: got %b@%0d expected %b@%0d", d, dat, oh, e[31:0]);
    end
    @(negedge clk);
    bus.req[0] = 1'b1;
    set_val(0, 2);
    wait_gnt(g, at);
    bus.req[0] = 1'b0;
    checks++; if (g !== 4'b0001) begin failures++; $display("FAIL cancel_gnt0: got %b expected 0001", g); end
    @(negedge clk);
    checks++; if (bus.remaining !== 8'd1) begin failures++; $display("FAIL cancel_cnt1: got %0d expected 1", bus.remaining); end
    bus.cancel[0] = 1'b1;
    @(negedge clk);
    bus.cancel[0] = 1'b0;
    checks++; if (bus.done !== '0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL cancel_last: got done=%b busy=%b expected 0/0", bus.done, bus.busy);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.done !== '0) begin failures++; $display("FAIL cancel_quiet: got %b expected 0", bus.done); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    bus.req[0] = 1'b1;
    set_val(0, 8);
    wait_gnt(g, at);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.remaining !== '0) begin
      failures++; $display("FAIL rstmid_async: got busy=%b rem=%0d expected 0/0", bus.busy, bus.remaining);
    end
    checks++; if (bus.gnt !== '0 || bus.done !== '0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL rstmid_pulses: got gnt=%b done=%b state=%0d expected 0/0/0", bus.gnt, bus.done, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    t0  = cyc;
    wait_gnt(g, at);
    bus.req[0] = 1'b0;
    checks++; if (g !== 4'b0001 || at !== t0 + 1 || bus.remaining !== 8'd8) begin
      failures++; $display("FAIL rstmid_regnt: got %b@%0d rem=%0d expected 0001@%0d rem=8", g, at, bus.remaining, t0 + 1);
    end
    push_done(0, at + 8);
    wait_done(d, dat);
    e  = exp_q.pop_front();
    oh = N'(1) << e[39:32];
    checks++; if (d !== oh || dat !== int'(e[31:0])) begin
      failures++; $display("FAIL rstmid_done: got %b@%0d expected %b@%0d", d, dat, oh, e[31:0]);
    end
  endtask

  task automatic test_value_capture();
    do_reset();
    @(negedge clk);
    bus.req[1] = 1'b1;
    set_val(1, 6);
    wait_gnt(g, at);
    push_done(1, at + 6);
    @(negedge clk);
    set_val(1, 3);
    bus.req[1] = 1'b0;
    wait_done(d, dat);
    e  = exp_q.pop_front();
    oh = N'(1) << e[39:32];
    checks++; if (d !== oh || dat !== int'(e[31:0])) begin
      failures++; $display("FAIL capture_done: got %b@%0d expected %b@%0d", d, dat, oh, e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_max();
    test_cancel();
    test_reset_mid();
    test_value_capture();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL queue_empty: got %0d expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
